rr_arb4_onehot: RTL and testbench

- 4-requester round-robin arbiter. Produces a registered one-hot grant word that drives the 4-to-2 encoder stage directly downstream, which turns it into a 2-bit requester index.
- Guarantees the encoder input is always all-zero or exactly one-hot. Grants are held until released, with one dead cycle between grants.
- Sits between the requester interfaces and the index-encoding stage.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 39 +++
 rtl/rr_arb4_onehot.sv | 139 +++++++++++++
 tb/tb_rr_arb4_onehot.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbitration stages.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [NUM_REQ-1:0] gnt_t;
  typedef logic [1:0]         idx_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Expand a requester index into its one-hot grant pattern.
  function automatic gnt_t idx_to_onehot(input idx_t idx);
    gnt_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick: rotate the request word so the
// pointer position sits at bit 0, take the lowest set bit, then rotate the
// winning index back. any_o is low when no request is present.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] win_oh_o,
  output logic [1:0] win_idx_o,
  output logic       any_o
);

  logic [3:0] rot;
  idx_t       rot_idx;
  idx_t       win_idx;
  logic       found;

  // Rotate, fixed-priority pick on the rotated word, un-rotate the index.
  always_comb begin
    rot     = '0;
    rot_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_i[idx_t'(i) + ptr_i];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found   = 1'b1;
        rot_idx = idx_t'(i);
      end
    end
    win_idx   = rot_idx + ptr_i;
    win_idx_o = win_idx;
    win_oh_o  = found ? idx_to_onehot(win_idx) : '0;
    any_o     = found;
  end

endmodule

// File: rtl/rr_arb4_onehot.sv
// 4-requester round-robin arbiter with a registered one-hot grant.
// A grant is held until the holder releases it (done_i or dropping its
// request) and is always followed by at least one all-zero cycle, so the
// downstream index encoder never sees two codes back to back.
// Optional forced release after TIMEOUT_CYC held cycles: RR_ARB_TIMEOUT_EN.
//
// Handshake: req_i is a level request; a requester owns the grant from the
// cycle gnt_o[i] is high until the edge at which done_i=1 or req_i[i]=0 is
// sampled; gnt_o is zero in the following cycle.
module rr_arb4_onehot
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic       gnt_valid_o,
  output logic       timeout_o,
  output logic       dbg_state_o
);

  // Reject an out-of-range hold limit at elaboration.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("rr_arb4_onehot: TIMEOUT_CYC must be within 2..255");
  end

  arb_state_t state_q, state_d;
  gnt_t       gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  idx_t       ptr_q, ptr_d;
  idx_t       idx_q, idx_d;

  gnt_t       pick_oh;
  idx_t       pick_idx;
  logic       pick_any;
  logic       normal_rel;
  logic       timeout_hit;

  rr_pick4 u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold counter: zero while idle (so it is clear on entry), counts GRANT cycles.
  always_comb begin
    cnt_d = '0;
    if (state_q == ARB_GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q == TIMEOUT_CYC-1 at an edge means the grant has been high TIMEOUT_CYC cycles.
  assign timeout_hit = (state_q == ARB_GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and grant logic; a release always passes through IDLE.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    timeout_d   = 1'b0;
    normal_rel  = done_i | ~req_i[idx_q];
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_GRANT;
          gnt_d       = pick_oh;
          gnt_valid_d = 1'b1;
          idx_d       = pick_idx;
        end
      end
      ARB_GRANT: begin
        if (normal_rel || timeout_hit) begin
          state_d     = ARB_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = idx_q + 2'd1;
          // A coinciding normal release takes precedence over the timeout.
          timeout_d   = timeout_hit & ~normal_rel;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;
  assign dbg_state_o = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_rr_arb4_onehot.sv
// Bench for rr_arb4_onehot: table of per-cycle vectors plus hand-written
// sequences for hold/timeout and asynchronous reset mid-grant.
module tb_rr_arb4_onehot;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_gnt;
    logic       exp_valid;
    logic       exp_to;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  rr_arb4_onehot #(.TIMEOUT_CYC(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] r, input logic d, input logic [3:0] g,
                         input logic v, input logic t);
    vecs[n_vec].req       = r;
    vecs[n_vec].done      = d;
    vecs[n_vec].exp_gnt   = g;
    vecs[n_vec].exp_valid = v;
    vecs[n_vec].exp_to    = t;
    n_vec++;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // Vector table: inputs applied, expected outputs after the next edge.
    add_vec(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);  // first grant, ptr=0
    // Rotation with all requesting, done each grant.
    add_vec(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0);
    add_vec(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0);
    add_vec(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0);
    add_vec(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0);
    add_vec(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);  // ptr=1
    // Hold on 0100 while req 0101 for ten cycles, then drop req[2].
    add_vec(4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) add_vec(4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0);
    add_vec(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);  // ptr=3
    add_vec(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);  // 3 wraps to 0
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);  // ptr=1
    // done together with a new request while granting 0010.
    add_vec(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
    add_vec(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0);  // ptr=2
    add_vec(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0);
    // done together with the request dropping: ptr advances once (3->0).
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
    add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);  // ptr=1
    // done is ignored while idle.
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0);
    add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);  // ptr=3

    // Reset state
    #12;
    chk("reset_gnt", {4'b0, gnt}, 8'h00);
    chk("reset_valid", {7'b0, gnt_valid}, 8'h00);
    chk("reset_timeout", {7'b0, timeout}, 8'h00);
    chk("reset_state", {7'b0, dbg_state}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_req", {4'b0, gnt}, 8'h00);

    // Table loop
    for (int i = 0; i < n_vec; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      chk($sformatf("vec%0d_gnt", i), {4'b0, gnt}, {4'b0, vecs[i].exp_gnt});
      chk($sformatf("vec%0d_valid", i), {7'b0, gnt_valid}, {7'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_timeout", i), {7'b0, timeout}, {7'b0, vecs[i].exp_to});
    end
    done = 1'b0;

    // Hold / timeout: ptr=3, req 0010 wins.
    req = 4'b0010;
    step();
    chk("hold_first_gnt", {4'b0, gnt}, 8'h02);
`ifdef RR_ARB_TIMEOUT_EN
    n = 0;
    while (gnt == 4'b0010 && n < 40) begin
      n++;
      chk("hold_no_timeout", {7'b0, timeout}, 8'h00);
      step();
    end
    chk("timeout_hold_len", 8'(n), 8'd16);
    chk("timeout_gnt_drop", {4'b0, gnt}, 8'h00);
    chk("timeout_pulse", {7'b0, timeout}, 8'h01);
    step();
    chk("timeout_pulse_end", {7'b0, timeout}, 8'h00);
    chk("timeout_regrant", {4'b0, gnt}, 8'h02);
`else
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (gnt == 4'b0010 && timeout == 1'b0) n++;
    end
    chk("hold_forever_cycles", 8'(n), 8'd30);
    chk("hold_forever_gnt", {4'b0, gnt}, 8'h02);
`endif

    // Asynchronous reset mid-grant.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", {4'b0, gnt}, 8'h00);
    chk("async_rst_valid", {7'b0, gnt_valid}, 8'h00);
    chk("async_rst_timeout", {7'b0, timeout}, 8'h00);
    step();
    chk("rst_held_gnt", {4'b0, gnt}, 8'h00);
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    chk("post_rst_gnt", {4'b0, gnt}, 8'h02);
    chk("post_rst_valid", {7'b0, gnt_valid}, 8'h01);
    chk("post_rst_state", {7'b0, dbg_state}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
